// File: rtl/aes128_key_expander.sv
// Iterative AES-128 key schedule: loads a cipher key on start and streams round keys
// 0..LAST_ROUND over a valid/ready handshake using external S-box and rcon stages.
module aes128_key_expander #(
  parameter int unsigned LAST_ROUND = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic [31:0]  sw_in,
  input  logic [31:0]  sw_out,
  output logic [31:0]  rc_word,
  output logic [3:0]   rc_round,
  input  logic [31:0]  rc_out,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         done
);

  localparam logic [3:0] LAST = 4'(LAST_ROUND);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;

  logic [31:0]  w0_s, w1_s, w2_s, w3_s;
  logic [31:0]  w0n_s, w1n_s, w2n_s, w3n_s;

  assign w0_s = key_q[127:96];
  assign w1_s = key_q[95:64];
  assign w2_s = key_q[63:32];
  assign w3_s = key_q[31:0];

  // RotWord(w3) leaves for the S-box; substituted word returns the same cycle for rcon
  assign sw_in    = {w3_s[23:0], w3_s[31:24]};
  assign rc_word  = sw_out;
  assign rc_round = (round_q == LAST) ? LAST : (round_q + 4'd1);

  assign w0n_s = w0_s ^ rc_out;
  assign w1n_s = w1_s ^ w0n_s;
  assign w2n_s = w2_s ^ w1n_s;
  assign w3n_s = w3_s ^ w2n_s;

  assign busy     = (state_q == EMIT);
  assign rk_valid = (state_q == EMIT);
  assign rk_data  = key_q;
  assign rk_round = round_q;
  assign done     = done_q;

  // Next-state: load on start in IDLE, advance or finish on each handshake in EMIT
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          round_d = 4'd0;
          state_d = EMIT;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (round_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = {w0n_s, w1n_s, w2n_s, w3n_s};
            round_d = round_q + 4'd1;
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, key and round registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= 128'd0;
      round_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_aes128_key_expander.sv
// Randomised self-checking bench for aes128_key_expander: external S-box/rcon models
// plus a word-by-word key-schedule reference computed from the AES rules.
module tb_aes128_key_expander;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sel;
  logic [127:0] key_in;
  logic         rk_ready;

  logic         start0, busy0, rk_valid0, done0;
  logic [31:0]  sw_in0, sw_out0, rc_word0, rc_out0;
  logic [3:0]   rc_round0, rk_round0;
  logic [127:0] rk_data0;

  logic         start1, busy1, rk_valid1, done1;
  logic [31:0]  sw_in1, sw_out1, rc_word1, rc_out1;
  logic [3:0]   rc_round1, rk_round1;
  logic [127:0] rk_data1;

  logic         obs_valid, obs_busy, obs_done;
  logic [3:0]   obs_round, obs_rc_round;
  logic [127:0] obs_data;

  logic [127:0] exp_rk [0:10];
  logic [127:0] cap    [0:10];
  int           checks = 0;
  int           errors = 0;
  int           stream_cycles;

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start1 = start & sel;

  aes128_key_expander dut0 (
    .clk(clk), .rst(rst), .start(start0), .key_in(key_in), .busy(busy0),
    .sw_in(sw_in0), .sw_out(sw_out0), .rc_word(rc_word0), .rc_round(rc_round0),
    .rc_out(rc_out0), .rk_valid(rk_valid0), .rk_ready(rk_ready), .rk_data(rk_data0),
    .rk_round(rk_round0), .done(done0)
  );

  aes128_key_expander #(.LAST_ROUND(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .key_in(key_in), .busy(busy1),
    .sw_in(sw_in1), .sw_out(sw_out1), .rc_word(rc_word1), .rc_round(rc_round1),
    .rc_out(rc_out1), .rk_valid(rk_valid1), .rk_ready(rk_ready), .rk_data(rk_data1),
    .rk_round(rk_round1), .done(done1)
  );

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int b = 1; b < 256; b++) begin
      if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int r);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 1; i < r; i++) rc = xtime(rc);
    return (r == 0) ? 8'h00 : rc;
  endfunction

  always_comb sw_out0 = sub_word(sw_in0);
  always_comb sw_out1 = sub_word(sw_in1);
  always_comb rc_out0 = rc_word0 ^ {rcon(int'(rc_round0)), 24'h000000};
  always_comb rc_out1 = rc_word1 ^ {rcon(int'(rc_round1)), 24'h000000};

  always_comb begin
    obs_valid    = sel ? rk_valid1 : rk_valid0;
    obs_busy     = sel ? busy1     : busy0;
    obs_done     = sel ? done1     : done0;
    obs_round    = sel ? rk_round1 : rk_round0;
    obs_rc_round = sel ? rc_round1 : rc_round0;
    obs_data     = sel ? rk_data1  : rk_data0;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference schedule in the textbook w[i] form over 44 words
  task automatic ref_schedule(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / 4), 24'h000000};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Called at a falling edge; returns at the falling edge where done is seen (or abort round)
  task automatic run_stream(input logic [127:0] key, input int last, input int ready_pct,
                            input int inject_at, input int abort_at);
    int r;
    int cyc;
    ref_schedule(key);
    key_in   = key;
    start    = 1'b1;
    rk_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    r   = 0;
    cyc = 0;
    while (r <= last && r != abort_at && cyc < 200) begin
      chk("rk_valid", 128'(obs_valid), 128'(1));
      chk("busy", 128'(obs_busy), 128'(1));
      chk("done_low", 128'(obs_done), 128'(0));
      chk("rk_round", 128'(obs_round), 128'(r));
      chk("rk_data", obs_data, exp_rk[r]);
      chk("rc_round", 128'(obs_rc_round), 128'((r == last) ? last : r + 1));
      rk_ready = ($urandom_range(0, 99) < ready_pct);
      start    = (r == inject_at);
      if (start) key_in = 128'd0;
      if (rk_ready) cap[r] = obs_data;
      @(negedge clk);
      cyc++;
      if (rk_ready) r++;
    end
    stream_cycles = cyc;
    start    = 1'b0;
    rk_ready = 1'b0;
    chk("stream_timeout", 128'(cyc < 200), 128'(1));
    if (r != abort_at) begin
      chk("end_valid", 128'(obs_valid), 128'(0));
      chk("end_busy", 128'(obs_busy), 128'(0));
      chk("done_pulse", 128'(obs_done), 128'(1));
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    sel      = 1'b0;
    rk_ready = 1'b0;
    key_in   = 128'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy0), 128'(0));
    chk("rst_valid", 128'(rk_valid0), 128'(0));
    chk("rst_data", rk_data0, 128'd0);
    chk("rst_round", 128'(rk_round0), 128'(0));
    chk("rst_done", 128'(done0), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 A.1 at full rate, then back-to-back restart in the done cycle
    run_stream(KEY_A1, 10, 100, -1, -1);
    chk("a1_cycles", 128'(stream_cycles), 128'(11));
    chk("a1_round0", cap[0], KEY_A1);
    chk("a1_round1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("a1_round10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_stream({$urandom, $urandom, $urandom, $urandom}, 10, 100, -1, -1);
    @(negedge clk);
    chk("done_one_cycle", 128'(done0), 128'(0));

    // Random backpressure, then a start while busy that must be ignored
    run_stream(KEY_A1, 10, 50, -1, -1);
    chk("bp_round10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(negedge clk);
    run_stream(KEY_A1, 10, 100, 3, -1);
    chk("ignored_start_round10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      run_stream({$urandom, $urandom, $urandom, $urandom}, 10, 70, -1, -1);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of round 5, then restart with the all-zero key
    run_stream(KEY_A1, 10, 100, -1, 5);
    chk("pre_rst_round", 128'(rk_round0), 128'(5));
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 128'(rk_valid0), 128'(0));
    chk("arst_busy", 128'(busy0), 128'(0));
    chk("arst_data", rk_data0, 128'd0);
    chk("arst_round", 128'(rk_round0), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    run_stream(128'd0, 10, 100, -1, -1);
    chk("zero_round1", cap[1], 128'h62636363626363636263636362636363);
    @(negedge clk);

    // Short schedule on the LAST_ROUND=4 instance
    sel = 1'b1;
    @(negedge clk);
    run_stream(KEY_A1, 4, 60, -1, -1);
    chk("short_round4", 128'(rk_round1), 128'(4));
    @(negedge clk);
    run_stream({$urandom, $urandom, $urandom, $urandom}, 4, 100, -1, -1);
    chk("short_cycles", 128'(stream_cycles), 128'(5));
    @(negedge clk);
    chk("short_done_low", 128'(done1), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
